pea_output_drain: RTL and testbench
===================================

// Module: pea_output_drain
// PURPOSE
//  Consumer end of the PEA output path: reads result/status word pairs from the two 32-bit output FIFOs
//  (written together by the PEA top module's wr_out) and serialises each pair onto a 16-bit valid/ready stream.
//  Sits between out_fifo_result/out_fifo_status and the host/testbench sink; replaces manual rd_en_* pulsing.
// PARAMETERS
//  POP_W    5   width of FIFO population inputs (log2 of output buffer_size = 32)
//  WIDTH    32  FIFO word width for result and status
//  OUT_W    16  output stream word width; WIDTH must equal 2*OUT_W
//  CNT_W    16  width of drained-pair counter
// PORTS
//  clk           in   1       clock
//  rst           in   1       reset
//  drain_en      in   1       1 = drain allowed; 0 = finish current pair, then idle
//  result_pop    in   POP_W   result FIFO population
//  status_pop    in   POP_W   status FIFO population
//  result_data   in   WIDTH   result FIFO read data
//  status_data   in   WIDTH   status FIFO read data
//  rd_en_result  out  1       result FIFO read strobe
//  rd_en_status  out  1       status FIFO read strobe
//  out_data      out  OUT_W   stream data
//  out_valid     out  1       stream valid
//  out_ready     in   1       stream ready from sink
//  busy          out  1       1 when not IDLE
//  pair_count    out  CNT_W   pairs fully transmitted since reset (wraps)
//  mismatch_err  out  1       sticky: result_pop != status_pop seen in IDLE
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high. All outputs 0 at reset; state IDLE.
//  - FSM: IDLE -> POP -> CAPTURE -> SEND -> IDLE (TAG precedes SEND when macro set).
//  - IDLE: go to POP when drain_en=1 and result_pop!=0 and status_pop!=0.
//  - POP: rd_en_result=rd_en_status=1 for exactly one cycle (both always together, never one alone).
//  - CAPTURE: FIFO read data valid the cycle after the strobe; latch {result_data,status_data} into 64-bit hold reg.
//  - SEND: 4 beats in order result[31:16], result[15:0], status[31:16], status[15:0].
//    Beat advances only on out_valid&&out_ready; out_data/out_valid stable while out_ready=0.
//  - After last beat accepted: pair_count+1 (mod 2^CNT_W), return IDLE; earliest next rd_en is 2 cycles later.
//  - Latency: rd_en to first out_valid = 2 cycles; pair throughput = 4 beats + 3 overhead cycles with ready=1.
//  - drain_en sampled only in IDLE; deasserting mid-pair does not abort the pair.
//  - Mismatch: in IDLE, result_pop!=status_pop sets mismatch_err (sticky until rst);
//    draining continues while both nonzero. Both-empty: stay IDLE, no strobes.
//  - Reset mid-pair: hold reg discarded, out_valid drops immediately, pair not counted.
// CONFIGURATION
//  PEA_DRAIN_TAG_EN defined: TAG state emits one extra leading beat {4'hA, pair_count[11:0]} before the 4 data beats
//    (5 beats/pair, same handshake rules).
//  Not defined: no TAG state, exactly 4 beats/pair.
// STRUCTURE
//  pea_drain_defs.vh (shared include): state encodings (IDLE, POP, CAPTURE, TAG, SEND), beat count, tag nibble 4'hA.
//  Sub-module pea_drain_serializer: 64-bit hold reg + beat index, valid/ready output; FSM stays in pea_output_drain.
// TESTING
//  1 pop=1/1, result=32'h0001_0002, status=32'h0000_0003, ready=1 -> beats 0001,0002,0000,0003; pair_count=1.
//  2 pops=3/3, ready toggling 1/0 each cycle -> 12 beats in order, no drop/dup, data held while ready=0.
//  3 result_pop=2, status_pop=1 -> mismatch_err=1 stays set; one pair drained, then IDLE.
//  4 drain_en=0 after first beat of pair -> pair completes (4 beats), no further rd_en strobes.
//  5 rst pulsed during SEND beat 2 -> out_valid=0 that cycle, pair_count=0, busy=0.
//  6 PEA_DRAIN_TAG_EN, 2 pairs -> beats A000,..4 data..,A001,..4 data..; pair_count=2.

Source files
------------

// File: rtl/pea_output_drain_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pea_output_drain_pkg
//  Description : Shared definitions for the PEA output drain: FSM state
//                encodings, beats per result/status pair and the tag nibble
//                that marks the optional leading tag beat.
//  Revision    : 1.0 - initial release
// ============================================================================
package pea_output_drain_pkg;

    localparam int         C_STATE_W        = 3;

    // FSM state encodings
    localparam logic [2:0] C_ST_IDLE        = 3'd0;
    localparam logic [2:0] C_ST_POP         = 3'd1;
    localparam logic [2:0] C_ST_CAPTURE     = 3'd2;
    localparam logic [2:0] C_ST_TAG         = 3'd3;
    localparam logic [2:0] C_ST_SEND        = 3'd4;

    // Data beats per result/status pair (tag beat not included)
    localparam int         C_BEATS_PER_PAIR = 4;

    // Upper nibble of the tag beat
    localparam logic [3:0] C_TAG_NIBBLE     = 4'hA;

endpackage : pea_output_drain_pkg
`default_nettype wire

// File: rtl/pea_output_drain_if.sv
`default_nettype none
// ============================================================================
//  Module      : pea_output_drain_if
//  Description : Bundles the FIFO read side (populations, read data, read
//                strobes) and the 16-bit valid/ready output stream of the
//                PEA output drain.
//                master : drain side (drives strobes and stream)
//                slave  : FIFO + sink side
//  Ports       : result_pop/status_pop  FIFO populations
//                result_data/status_data FIFO read data (valid 1 cycle after strobe)
//                rd_en_result/rd_en_status FIFO read strobes
//                out_data/out_valid/out_ready output stream
//  Revision    : 1.0 - initial release
// ============================================================================
interface pea_output_drain_if #(
    parameter int POP_W = 5,
    parameter int WIDTH = 32,
    parameter int OUT_W = 16
);
    logic [POP_W-1:0] result_pop;
    logic [POP_W-1:0] status_pop;
    logic [WIDTH-1:0] result_data;
    logic [WIDTH-1:0] status_data;
    logic             rd_en_result;
    logic             rd_en_status;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        input  result_pop, status_pop, result_data, status_data, out_ready,
        output rd_en_result, rd_en_status, out_data, out_valid
    );

    modport slave (
        output result_pop, status_pop, result_data, status_data, out_ready,
        input  rd_en_result, rd_en_status, out_data, out_valid
    );
endinterface : pea_output_drain_if
`default_nettype wire

// File: rtl/pea_drain_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : pea_drain_serializer
//  Description : Holds one {result,status} pair and presents it as four
//                OUT_W-bit beats, most significant half of result first.
//                The beat index only advances on an accepted beat, so data
//                stays put while the sink stalls.
//  Ports       : clk, rst     clock, asynchronous active-high reset
//                load_i       capture result_i/status_i, restart at beat 0
//                result_i     result word
//                status_i     status word
//                send_i       FSM is in the data-beat phase
//                ready_i      sink ready
//                data_o       current beat
//                valid_o      beat valid
//                last_o       final beat accepted this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module pea_drain_serializer
    import pea_output_drain_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] result_i,
    input  logic [WIDTH-1:0] status_i,
    input  logic             send_i,
    input  logic             ready_i,
    output logic [OUT_W-1:0] data_o,
    output logic             valid_o,
    output logic             last_o
);

    logic [2*WIDTH-1:0] hold_q, hold_d;
    logic [1:0]         beat_q, beat_d;
    logic               accept;

    assign accept  = send_i && ready_i;
    assign valid_o = send_i;
    assign last_o  = accept && (beat_q == 2'(C_BEATS_PER_PAIR - 1));

    always_comb begin
        hold_d = hold_q;
        beat_d = beat_q;
        if (load_i) begin
            hold_d = {result_i, status_i};
            beat_d = 2'd0;
        end else if (accept) begin
            beat_d = beat_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            beat_q <= 2'd0;
        end else begin
            hold_q <= hold_d;
            beat_q <= beat_d;
        end
    end

    // Beat order: result hi, result lo, status hi, status lo
    always_comb begin
        data_o = hold_q[OUT_W-1:0];
        case (beat_q)
            2'd0:    data_o = hold_q[2*WIDTH-1 -: OUT_W];
            2'd1:    data_o = hold_q[WIDTH+OUT_W-1 -: OUT_W];
            2'd2:    data_o = hold_q[WIDTH-1 -: OUT_W];
            default: data_o = hold_q[OUT_W-1:0];
        endcase
    end

endmodule : pea_drain_serializer
`default_nettype wire

// File: rtl/pea_output_drain.sv
`default_nettype none
// ============================================================================
//  Module      : pea_output_drain
//  Description : Consumer end of the PEA output path. Pops one word from the
//                result and status FIFOs together and serialises the pair
//                onto a 16-bit valid/ready stream, counting completed pairs
//                and flagging population mismatches.
//  Config      : PEA_DRAIN_TAG_EN - when defined, each pair is preceded by a
//                tag beat {4'hA, pair_count[11:0]} (5 beats per pair).
//  Ports       : clk, rst        clock, asynchronous active-high reset
//                drain_en_i      drain allowed (sampled in IDLE only)
//                bus (master)    FIFO read side + output stream
//                busy_o          FSM not in IDLE
//                pair_count_o    pairs fully transmitted since reset (wraps)
//                mismatch_err_o  sticky: populations differed while IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module pea_output_drain
    import pea_output_drain_pkg::*;
#(
    parameter int POP_W = 5,
    parameter int WIDTH = 32,
    parameter int OUT_W = 16,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 drain_en_i,
    pea_output_drain_if.master   bus,
    output logic                 busy_o,
    output logic [CNT_W-1:0]     pair_count_o,
    output logic                 mismatch_err_o
);

    logic [C_STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]     pair_count_q, pair_count_d;
    logic                 mismatch_q, mismatch_d;

    logic                 both_avail;
    logic                 ser_valid;
    logic                 ser_last;
    logic [OUT_W-1:0]     ser_data;

    assign both_avail = (bus.result_pop != '0) && (bus.status_pop != '0);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            C_ST_IDLE: begin
                if (drain_en_i && both_avail) begin
                    state_d = C_ST_POP;
                end
            end
            C_ST_POP: begin
                state_d = C_ST_CAPTURE;
            end
            C_ST_CAPTURE: begin
`ifdef PEA_DRAIN_TAG_EN
                state_d = C_ST_TAG;
`else
                state_d = C_ST_SEND;
`endif
            end
`ifdef PEA_DRAIN_TAG_EN
            C_ST_TAG: begin
                if (bus.out_ready) begin
                    state_d = C_ST_SEND;
                end
            end
`endif
            C_ST_SEND: begin
                if (ser_last) begin
                    state_d = C_ST_IDLE;
                end
            end
            default: begin
                state_d = C_ST_IDLE;
            end
        endcase
    end

    always_comb begin
        pair_count_d = pair_count_q;
        if (ser_last) begin
            pair_count_d = pair_count_q + 1'b1;
        end
    end

    // Mismatch is only judged in IDLE: while a pair is in flight the two
    // populations legitimately move apart for a cycle around the strobe.
    always_comb begin
        mismatch_d = mismatch_q;
        if ((state_q == C_ST_IDLE) && (bus.result_pop != bus.status_pop)) begin
            mismatch_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= C_ST_IDLE;
            pair_count_q <= '0;
            mismatch_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pair_count_q <= pair_count_d;
            mismatch_q   <= mismatch_d;
        end
    end

    // ------------------------------------------------------------------
    // Serializer: loads in CAPTURE, when FIFO read data is valid
    // ------------------------------------------------------------------
    pea_drain_serializer #(
        .WIDTH (WIDTH),
        .OUT_W (OUT_W)
    ) u_serializer (
        .clk      (clk),
        .rst      (rst),
        .load_i   (state_q == C_ST_CAPTURE),
        .result_i (bus.result_data),
        .status_i (bus.status_data),
        .send_i   (state_q == C_ST_SEND),
        .ready_i  (bus.out_ready),
        .data_o   (ser_data),
        .valid_o  (ser_valid),
        .last_o   (ser_last)
    );

    // ------------------------------------------------------------------
    // Outputs (decoded from registered state, so reset drops them at once)
    // ------------------------------------------------------------------
    assign bus.rd_en_result = (state_q == C_ST_POP);
    assign bus.rd_en_status = (state_q == C_ST_POP);
    assign busy_o           = (state_q != C_ST_IDLE);
    assign pair_count_o     = pair_count_q;
    assign mismatch_err_o   = mismatch_q;

    always_comb begin
        bus.out_data  = ser_data;
        bus.out_valid = ser_valid;
`ifdef PEA_DRAIN_TAG_EN
        if (state_q == C_ST_TAG) begin
            bus.out_data  = OUT_W'({C_TAG_NIBBLE, pair_count_q[11:0]});
            bus.out_valid = 1'b1;
        end
`endif
    end

endmodule : pea_output_drain
`default_nettype wire

// File: tb/tb_pea_output_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pea_output_drain
//  Description : Self-checking bench for pea_output_drain. Models the two
//                output FIFOs as queues with one-cycle read latency and
//                predicts the beat stream from the pair-serialisation rules.
//  Config      : follows PEA_DRAIN_TAG_EN for the expected beat stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pea_output_drain;

    localparam int POP_W = 5;
    localparam int WIDTH = 32;
    localparam int OUT_W = 16;
    localparam int CNT_W = 16;
`ifdef PEA_DRAIN_TAG_EN
    localparam int BPP    = 5;  // beats per pair
    localparam int PERIOD = 8;  // cycles per pair with ready held high
`else
    localparam int BPP    = 4;
    localparam int PERIOD = 7;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             drain_en = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] pair_count;
    logic             mismatch_err;

    pea_output_drain_if #(.POP_W(POP_W), .WIDTH(WIDTH), .OUT_W(OUT_W)) bus ();

    pea_output_drain #(
        .POP_W (POP_W), .WIDTH (WIDTH), .OUT_W (OUT_W), .CNT_W (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .drain_en_i     (drain_en),
        .bus            (bus.master),
        .busy_o         (busy),
        .pair_count_o   (pair_count),
        .mismatch_err_o (mismatch_err)
    );

    always #5 clk = ~clk;

    // Scoreboard / model state
    int          checks = 0;
    int          errors = 0;
    logic [31:0] qr[$];
    logic [31:0] qs[$];
    logic [15:0] got[$];
    logic [15:0] exp_beats[$];
    int          rd_cyc[$];
    int          rd_count = 0;
    int          cyc = 0;
    int          first_valid_cyc = -1;
    int          exp_pairs = 0;
    int          ready_mode = 0;  // 0: always 1, 1: toggle, 2: random
    bit          prev_v = 0;
    bit          prev_stall = 0;
    logic [15:0] prev_d = '0;
    bit          pend_v = 0;
    logic [31:0] pend_r = '0;
    logic [31:0] pend_s = '0;

    typedef struct packed {
        logic [31:0]         res;
        logic [31:0]         sta;
        logic [0:3][15:0]    b;
    } vec_t;
    vec_t tbl[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic model_tag();
`ifdef PEA_DRAIN_TAG_EN
        exp_beats.push_back({4'hA, exp_pairs[11:0]});
`endif
    endtask

    task automatic model_pair(input logic [31:0] r, input logic [31:0] s);
        model_tag();
        exp_beats.push_back(r[31:16]);
        exp_beats.push_back(r[15:0]);
        exp_beats.push_back(s[31:16]);
        exp_beats.push_back(s[15:0]);
        exp_pairs++;
    endtask

    // One clock: sample at negedge, then drive FIFO data/pops/ready at posedge+1
    task automatic step();
        logic        v, rr, rs;
        logic [15:0] d;
        @(negedge clk);
        v  = bus.out_valid;
        d  = bus.out_data;
        rr = bus.rd_en_result;
        rs = bus.rd_en_status;
        if (!rst) begin
            if (rr || rs) check("rd_en_together", 64'(rr), 64'(rs));
            if (prev_stall) begin
                check("hold_valid", 64'(v), 64'd1);
                check("hold_data", 64'(d), 64'(prev_d));
            end
            if (v && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (v && bus.out_ready) got.push_back(d);
            if (rr) begin
                rd_count++;
                rd_cyc.push_back(cyc);
                pend_r = (qr.size() > 0) ? qr.pop_front() : 32'hBAD0_BAD0;
                pend_s = (qs.size() > 0) ? qs.pop_front() : 32'hBAD1_BAD1;
                pend_v = 1;
            end
            prev_stall = v && !bus.out_ready;
            prev_d     = d;
            prev_v     = v;
        end else begin
            prev_stall = 0;
            prev_v     = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pend_v) begin
            bus.result_data = pend_r;
            bus.status_data = pend_s;
            pend_v = 0;
        end else begin
            bus.result_data = $urandom;
            bus.status_data = $urandom;
        end
        bus.result_pop = POP_W'(qr.size());
        bus.status_pop = POP_W'(qs.size());
        case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ~bus.out_ready;
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic run_until(input int n, input int budget, input string name);
        int k = 0;
        while (got.size() < n && k < budget) begin
            step();
            k++;
        end
        check(name, 64'(got.size()), 64'(n));
        repeat (3) step();
    endtask

    task automatic compare_beats(input string name);
        int n = exp_beats.size();
        check(name, 64'(got.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (i < got.size()) check("beat_data", 64'(got[i]), 64'(exp_beats[i]));
        end
        got.delete();
        exp_beats.delete();
    endtask

    task automatic begin_test(input int mode);
        ready_mode      = mode;
        rd_count        = 0;
        first_valid_cyc = -1;
        rd_cyc.delete();
        got.delete();
        exp_beats.delete();
    endtask

    initial begin
        logic [31:0] r, s;
        int          k;

        bus.result_pop  = '0;
        bus.status_pop  = '0;
        bus.result_data = '0;
        bus.status_data = '0;
        bus.out_ready   = 1'b1;

        // ---------------- reset state ----------------
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_rd_en", 64'(bus.rd_en_result), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pair_count", 64'(pair_count), 64'd0);
        check("rst_mismatch", 64'(mismatch_err), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) step();
        check("idle_empty_no_rd", 64'(rd_count), 64'd0);

        // ---------------- table-driven pairs, ready=1 ----------------
        tbl[0] = '{32'h0001_0002, 32'h0000_0003, {16'h0001, 16'h0002, 16'h0000, 16'h0003}};
        tbl[1] = '{32'hDEAD_BEEF, 32'h1234_5678, {16'hDEAD, 16'hBEEF, 16'h1234, 16'h5678}};
        tbl[2] = '{32'hFFFF_0000, 32'h0000_FFFF, {16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF}};
        tbl[3] = '{32'h8001_7FFE, 32'hA5A5_5A5A, {16'h8001, 16'h7FFE, 16'hA5A5, 16'h5A5A}};
        begin_test(0);
        drain_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            qr.push_back(tbl[i].res);
            qs.push_back(tbl[i].sta);
            model_tag();
            for (int j = 0; j < 4; j++) exp_beats.push_back(tbl[i].b[j]);
            exp_pairs++;
        end
        run_until(4 * BPP, 200, "table_beats_arrived");
        compare_beats("table_beat_count");
        check("table_rd_count", 64'(rd_count), 64'd4);
        if (rd_cyc.size() >= 4) begin
            check("latency_rd_to_valid", 64'(first_valid_cyc - rd_cyc[0]), 64'd2);
            check("pair_period", 64'(rd_cyc[1] - rd_cyc[0]), 64'(PERIOD));
            check("pair_period_x3", 64'(rd_cyc[3] - rd_cyc[0]), 64'(3 * PERIOD));
        end
        check("table_pair_count", 64'(pair_count), 64'(exp_pairs));
        check("table_busy_idle", 64'(busy), 64'd0);
        check("table_no_mismatch", 64'(mismatch_err), 64'd0);

        // ---------------- 3 pairs, ready toggling ----------------
        begin_test(1);
        for (int i = 0; i < 3; i++) begin
            r = $urandom;
            s = $urandom;
            qr.push_back(r);
            qs.push_back(s);
            model_pair(r, s);
        end
        run_until(3 * BPP, 300, "toggle_beats_arrived");
        compare_beats("toggle_beat_count");
        check("toggle_rd_count", 64'(rd_count), 64'd3);
        check("toggle_pair_count", 64'(pair_count), 64'(exp_pairs));

        // ---------------- population mismatch 2/1 ----------------
        begin_test(0);
        r = $urandom;
        s = $urandom;
        qr.push_back(r);
        qr.push_back($urandom);
        qs.push_back(s);
        model_pair(r, s);
        run_until(BPP, 100, "mismatch_beats_arrived");
        repeat (10) step();
        compare_beats("mismatch_beat_count");
        check("mismatch_rd_count", 64'(rd_count), 64'd1);
        check("mismatch_flag", 64'(mismatch_err), 64'd1);
        check("mismatch_busy_idle", 64'(busy), 64'd0);
        qr.delete();
        repeat (3) step();
        check("mismatch_sticky", 64'(mismatch_err), 64'd1);
        check("mismatch_pair_count", 64'(pair_count), 64'(exp_pairs));

        // ---------------- drain_en dropped mid-pair ----------------
        begin_test(0);
        for (int i = 0; i < 2; i++) begin
            r = $urandom;
            s = $urandom;
            qr.push_back(r);
            qs.push_back(s);
            model_pair(r, s);
        end
        k = 0;
        while (got.size() < 1 && k < 50) begin
            step();
            k++;
        end
        drain_en = 1'b0;
        repeat (30) step();
        check("dis_beats_one_pair", 64'(got.size()), 64'(BPP));
        check("dis_rd_count", 64'(rd_count), 64'd1);
        check("dis_busy_idle", 64'(busy), 64'd0);
        drain_en = 1'b1;
        run_until(2 * BPP, 100, "dis_resume_beats");
        compare_beats("dis_beat_count");
        check("dis_pair_count", 64'(pair_count), 64'(exp_pairs));

        // ---------------- randomized pairs, random ready ----------------
        begin_test(2);
        for (int i = 0; i < 6; i++) begin
            r = $urandom;
            s = $urandom;
            qr.push_back(r);
            qs.push_back(s);
            model_pair(r, s);
        end
        run_until(6 * BPP, 600, "rand_beats_arrived");
        compare_beats("rand_beat_count");
        check("rand_pair_count", 64'(pair_count), 64'(exp_pairs));

        // ---------------- reset during data beat 2 ----------------
        begin_test(0);
        qr.push_back($urandom);
        qs.push_back($urandom);
        k = 0;
        while (got.size() < BPP - 2 && k < 50) begin
            step();
            k++;
        end
        check("pre_rst_in_send", 64'(bus.out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_pair_count", 64'(pair_count), 64'd0);
        check("rst_mid_mismatch", 64'(mismatch_err), 64'd0);
        repeat (2) step();
        rst = 1'b0;
        begin_test(0);
        exp_pairs = 0;
        r = $urandom;
        s = $urandom;
        qr.push_back(r);
        qs.push_back(s);
        model_pair(r, s);
        run_until(BPP, 100, "post_rst_beats");
        compare_beats("post_rst_beat_count");
        check("post_rst_pair_count", 64'(pair_count), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule : tb_pea_output_drain
`default_nettype wire
